// File: rtl/fifo_sync_wc.sv
// Width-converting sync FIFO: packs pRATIO narrow writes into wide words, stores and reads wide words.
// Latency: a completed or flushed word is readable the cycle after its push; rdata is registered unless pFALLTHROUGH.
// Backpressure: writes are dropped with an overflow pulse when full; reads on empty give an underflow pulse. Optional max_level via FIFO_SYNC_WC_HIGHWATER_EN.
module fifo_sync_wc #(
    parameter int pIN_WIDTH    = 8,
    parameter int pRATIO       = 4,
    parameter int pDEPTH       = 32,
    parameter int pFALLTHROUGH = 0,
    localparam int pADDR_WIDTH = $clog2(pDEPTH),
    localparam int pOUT_WIDTH  = pIN_WIDTH * pRATIO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wen,
    input  logic [pIN_WIDTH-1:0]   wdata,
    input  logic                   flush,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ren,
    output logic [pOUT_WIDTH-1:0]  rdata,
    output logic                   empty,
    output logic                   underflow,
    output logic [pADDR_WIDTH:0]   level,
    output logic [2:0]             partial,
    input  logic [pADDR_WIDTH:0]   af_thresh,
    output logic                   almost_full,
    input  logic [pADDR_WIDTH:0]   ae_thresh,
    output logic                   almost_empty,
    output logic [pADDR_WIDTH:0]   max_level
);

    localparam logic [2:0]           LAST_SLOT = 3'(pRATIO - 1);
    localparam logic [pADDR_WIDTH:0] DEPTH_LVL = (pADDR_WIDTH + 1)'(pDEPTH);

    logic [pADDR_WIDTH:0]  wptr_q, rptr_q;
    logic [2:0]            partial_q, partial_d;
    logic [pOUT_WIDTH-1:0] pack_q, pack_merged;
    logic                  overflow_q, underflow_q;
    logic [pOUT_WIDTH-1:0] mem [pDEPTH];

    logic store_full, wr_acc, rd_acc, word_push, flush_push, push, pending;

    assign level      = wptr_q - rptr_q;
    assign empty      = (level == '0);
    assign store_full = (level == DEPTH_LVL);
    // Full only once the pack register is also one slot from completing a word
    assign full       = store_full && (partial_q == LAST_SLOT);

    assign wr_acc     = wen && !full && !clear;
    assign rd_acc     = ren && !empty && !clear;
    assign word_push  = wr_acc && (partial_q == LAST_SLOT);
    assign pending    = (partial_q != 3'd0) || wr_acc;
    assign flush_push = flush && !clear && !word_push && pending && !store_full;
    assign push       = word_push || flush_push;

    always_comb begin
        pack_merged = pack_q;
        for (int k = 0; k < pRATIO; k++) begin
            if (wr_acc && (partial_q == 3'(k)))
                pack_merged[k*pIN_WIDTH +: pIN_WIDTH] = wdata;
        end
    end

    always_comb begin
        partial_d = partial_q;
        if (push)
            partial_d = 3'd0;
        else if (wr_acc)
            partial_d = partial_q + 3'd1;
    end

    // Pack register is zeroed after every push so flushed words are zero-padded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            partial_q   <= 3'd0;
            pack_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            partial_q   <= 3'd0;
            pack_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (rd_acc)
                rptr_q <= rptr_q + 1'b1;
            partial_q   <= partial_d;
            pack_q      <= push ? '0 : pack_merged;
            overflow_q  <= wen && full;
            underflow_q <= ren && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_q[pADDR_WIDTH-1:0]] <= pack_merged;
    end

    generate
        if (pFALLTHROUGH != 0) begin : g_fwft
            assign rdata = mem[rptr_q[pADDR_WIDTH-1:0]];
        end else begin : g_reg_rd
            logic [pOUT_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rdata_q <= '0;
                else if (rd_acc)
                    rdata_q <= mem[rptr_q[pADDR_WIDTH-1:0]];
            end
            assign rdata = rdata_q;
        end
    endgenerate

    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign partial      = partial_q;
    assign almost_full  = (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);

`ifdef FIFO_SYNC_WC_HIGHWATER_EN
    logic [pADDR_WIDTH:0] max_level_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_level_q <= '0;
        else if (clear)
            max_level_q <= '0;
        else if (level > max_level_q)
            max_level_q <= level;
    end
    assign max_level = max_level_q;
`else
    assign max_level = '0;
`endif

endmodule
